// File: rtl/ff_bank_if.sv
// Bundle of data and status signals for the ff_bank flip-flop array.
// The master drives the controls; the slave (ff_bank) returns state and error status.
interface ff_bank_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             clr_err;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q1;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;
   logic             err_sticky;

   modport master (
      output en, mode, a, b, clr_err,
      input  q, q1, illegal, illegal_cnt, err_sticky
   );

   modport slave (
      input  en, mode, a, b, clr_err,
      output q, q1, illegal, illegal_cnt, err_sticky
   );
endinterface

// File: rtl/ff_bank.sv
// Bank of WIDTH flip-flops with a shared runtime SR/JK/D/T update rule.
// It also monitors forbidden SR stimulus (pulse, saturating counter, sticky flag).
module ff_bank #(
   parameter int               WIDTH     = 4,
   parameter int               SR_BOTH   = 0,
   parameter int               CNT_W     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input logic     clk,
   input logic     rst,
   ff_bank_if.slave bus
);
   localparam logic [1:0] MODE_SR = 2'b00;
   localparam logic [1:0] MODE_JK = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;
   localparam logic [1:0] MODE_T  = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic             r_illegal;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sticky;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_illegal;
   logic [CNT_W-1:0] w_cnt_base;
   logic             w_sticky_base;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic sr_both_bit(input logic cur);
      if (SR_BOTH == 1)      return 1'b1;
      else if (SR_BOTH == 2) return 1'b0;
      else                   return cur;
   endfunction

   always_comb begin
      w_q_nxt = r_q;
      for (int i = 0; i < WIDTH; i++) begin
         case (bus.mode)
            MODE_SR: begin
               case ({bus.a[i], bus.b[i]})
                  2'b10:   w_q_nxt[i] = 1'b1;
                  2'b01:   w_q_nxt[i] = 1'b0;
                  2'b11:   w_q_nxt[i] = sr_both_bit(r_q[i]);
                  default: w_q_nxt[i] = r_q[i];
               endcase
            end
            MODE_JK: begin
               case ({bus.a[i], bus.b[i]})
                  2'b10:   w_q_nxt[i] = 1'b1;
                  2'b01:   w_q_nxt[i] = 1'b0;
                  2'b11:   w_q_nxt[i] = ~r_q[i];
                  default: w_q_nxt[i] = r_q[i];
               endcase
            end
            MODE_D:  w_q_nxt[i] = bus.a[i];
            MODE_T:  w_q_nxt[i] = r_q[i] ^ bus.a[i];
            default: w_q_nxt[i] = r_q[i];
         endcase
      end
   end

   // Any colliding bit counts the cycle once; clr_err is applied before counting.
   assign w_illegal     = bus.en && (bus.mode == MODE_SR) && (|(bus.a & bus.b));
   assign w_cnt_base    = bus.clr_err ? '0 : r_cnt;
   assign w_sticky_base = bus.clr_err ? 1'b0 : r_sticky;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q       <= RESET_VAL;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
         r_sticky  <= 1'b0;
      end else begin
         if (bus.en) r_q <= w_q_nxt;
         r_illegal <= w_illegal;
         if (w_illegal) begin
            r_cnt    <= sat_inc(w_cnt_base);
            r_sticky <= 1'b1;
         end else begin
            r_cnt    <= w_cnt_base;
            r_sticky <= w_sticky_base;
         end
      end
   end

   assign bus.q           = r_q;
   assign bus.q1          = ~r_q;
   assign bus.illegal     = r_illegal;
   assign bus.illegal_cnt = r_cnt;
   assign bus.err_sticky  = r_sticky;
endmodule

// File: tb/tb_ff_bank.sv
// Directed self-checking bench for ff_bank: four instances cover reset value,
// SR resolution policies, counter saturation, enable gating and JK/T/D modes.
module tb_ff_bank;
   logic       clk = 1'b0;
   logic       rst_a, rst_b, rst_c, rst_d;
   logic       en, clr_err;
   logic [1:0] mode;
   logic [3:0] a, b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ff_bank_if #(.WIDTH(4), .CNT_W(8)) if_a ();
   ff_bank_if #(.WIDTH(4), .CNT_W(8)) if_b ();
   ff_bank_if #(.WIDTH(4), .CNT_W(8)) if_c ();
   ff_bank_if #(.WIDTH(4), .CNT_W(2)) if_d ();

   assign if_a.en = en; assign if_a.mode = mode; assign if_a.a = a; assign if_a.b = b; assign if_a.clr_err = clr_err;
   assign if_b.en = en; assign if_b.mode = mode; assign if_b.a = a; assign if_b.b = b; assign if_b.clr_err = clr_err;
   assign if_c.en = en; assign if_c.mode = mode; assign if_c.a = a; assign if_c.b = b; assign if_c.clr_err = clr_err;
   assign if_d.en = en; assign if_d.mode = mode; assign if_d.a = a; assign if_d.b = b; assign if_d.clr_err = clr_err;

   ff_bank #(.WIDTH(4), .SR_BOTH(0), .CNT_W(8), .RESET_VAL(4'b0101)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
   ff_bank #(.WIDTH(4), .SR_BOTH(1), .CNT_W(8), .RESET_VAL(4'b0000)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
   ff_bank #(.WIDTH(4), .SR_BOTH(2), .CNT_W(8), .RESET_VAL(4'b0000)) dut_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));
   ff_bank #(.WIDTH(4), .SR_BOTH(0), .CNT_W(2), .RESET_VAL(4'b0000)) dut_d (.clk(clk), .rst(rst_d), .bus(if_d.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] va,
                        input logic [3:0] vb, input logic c);
      en = e; mode = m; a = va; b = vb; clr_err = c;
      cycle();
   endtask

   task automatic chk_d(input string tag, input logic [3:0] q, input logic ill,
                        input logic [1:0] cnt, input logic st);
      check({tag, ".q"},   32'(if_d.q), 32'(q));
      check({tag, ".ill"}, 32'(if_d.illegal), 32'(ill));
      check({tag, ".cnt"}, 32'(if_d.illegal_cnt), 32'(cnt));
      check({tag, ".st"},  32'(if_d.err_sticky), 32'(st));
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
      #2;
      // Reset wins over an illegal SR stimulus
      drive(1'b1, 2'b00, 4'hF, 4'hF, 1'b1);
      check("rst.q",   32'(if_a.q), 32'h5);
      check("rst.q1",  32'(if_a.q1), 32'hA);
      check("rst.ill", 32'(if_a.illegal), 32'h0);
      check("rst.cnt", 32'(if_a.illegal_cnt), 32'h0);
      check("rst.st",  32'(if_a.err_sticky), 32'h0);

      // SR sequence with hold policy
      rst_d = 1'b1;
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0); chk_d("sr0", 4'b0000, 1'b0, 2'd0, 1'b0);
      drive(1'b1, 2'b00, 4'b0011, 4'b0000, 1'b0); chk_d("sr1", 4'b0011, 1'b0, 2'd0, 1'b0);
      drive(1'b1, 2'b00, 4'b0000, 4'b0001, 1'b0); chk_d("sr2", 4'b0010, 1'b0, 2'd0, 1'b0);
      drive(1'b1, 2'b00, 4'b0100, 4'b0100, 1'b0); chk_d("sr3", 4'b0010, 1'b1, 2'd1, 1'b1);
      check("sr3.q1", 32'(if_d.q1), 32'hD);
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0); chk_d("sr4", 4'b0010, 1'b0, 2'd1, 1'b1);

      // Counter saturation and clear interaction
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b1); chk_d("clr0", 4'b0010, 1'b0, 2'd0, 1'b0);
      drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b0); chk_d("cnt1", 4'b0010, 1'b1, 2'd1, 1'b1);
      drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b0); chk_d("cnt2", 4'b0010, 1'b1, 2'd2, 1'b1);
      drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b0); chk_d("cnt3", 4'b0010, 1'b1, 2'd3, 1'b1);
      drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b0); chk_d("cnt4", 4'b0010, 1'b1, 2'd3, 1'b1);
      drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b1); chk_d("clrill", 4'b0010, 1'b1, 2'd1, 1'b1);
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b1); chk_d("clr1", 4'b0010, 1'b0, 2'd0, 1'b0);

      // Enable gating
      drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b0); chk_d("en0", 4'b0010, 1'b1, 2'd1, 1'b1);
      drive(1'b0, 2'b00, 4'b1111, 4'b1111, 1'b0); chk_d("en1", 4'b0010, 1'b0, 2'd1, 1'b1);
      drive(1'b0, 2'b10, 4'b1111, 4'b0000, 1'b0); chk_d("en2", 4'b0010, 1'b0, 2'd1, 1'b1);
      drive(1'b0, 2'b00, 4'b1111, 4'b1111, 1'b1); chk_d("en3", 4'b0010, 1'b0, 2'd0, 1'b0);

      // Mid-operation reset discards state
      drive(1'b1, 2'b00, 4'b0001, 4'b0001, 1'b0); chk_d("pre", 4'b0010, 1'b1, 2'd1, 1'b1);
      rst_d = 1'b0;
      drive(1'b1, 2'b00, 4'b1111, 4'b1111, 1'b0); chk_d("midrst", 4'b0000, 1'b0, 2'd0, 1'b0);

      // Set-dominant vs reset-dominant policies
      rst_b = 1'b1; rst_c = 1'b1;
      drive(1'b1, 2'b00, 4'b1111, 4'b1111, 1'b0);
      check("setdom.q",   32'(if_b.q), 32'hF);
      check("setdom.ill", 32'(if_b.illegal), 32'h1);
      check("setdom.st",  32'(if_b.err_sticky), 32'h1);
      check("rstdom.q",   32'(if_c.q), 32'h0);
      check("rstdom.ill", 32'(if_c.illegal), 32'h1);
      check("rstdom.cnt", 32'(if_c.illegal_cnt), 32'h1);
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0);
      check("setdom.ill2", 32'(if_b.illegal), 32'h0);
      check("rstdom.ill2", 32'(if_c.illegal), 32'h0);

      // JK / T / D modes and mode carry-over on the 0101-reset instance
      rst_a = 1'b1;
      drive(1'b1, 2'b10, 4'b0000, 4'b0000, 1'b0); check("d0.q", 32'(if_a.q), 32'h0);
      drive(1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0); check("jk1.q", 32'(if_a.q), 32'hF);
      check("jk1.ill", 32'(if_a.illegal), 32'h0);
      drive(1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0); check("jk2.q", 32'(if_a.q), 32'h0);
      drive(1'b1, 2'b01, 4'b1000, 4'b0001, 1'b0); check("jk3.q", 32'(if_a.q), 32'h8);
      drive(1'b1, 2'b11, 4'b1010, 4'b1111, 1'b0); check("t.q", 32'(if_a.q), 32'h2);
      drive(1'b1, 2'b11, 4'b0000, 4'b1111, 1'b0); check("thold.q", 32'(if_a.q), 32'h2);
      drive(1'b1, 2'b10, 4'b0110, 4'b1111, 1'b0); check("d.q", 32'(if_a.q), 32'h6);
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0); check("srhold.q", 32'(if_a.q), 32'h6);
      check("srhold.q1",  32'(if_a.q1), 32'h9);
      check("modes.ill",  32'(if_a.illegal), 32'h0);
      check("modes.cnt",  32'(if_a.illegal_cnt), 32'h0);
      check("modes.st",   32'(if_a.err_sticky), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
